// File: rtl/crc_code_encoder.sv
// crc_code_encoder: serial CRC-4 (x^4 + x + 1) encoder for one byte.
// A byte is shifted MSB first through a 4-bit LFSR over eight cycles.
// The codeword {message, crc} is then held until downstream takes it.
// Optional feature macro: CRC_ENC_ERR_INJECT_EN.
// When it is defined, inject_err flips the CRC LSB of that codeword.
module crc_code_encoder (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  data_in,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        inject_err,
    output logic [11:0] encoded_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy
);

`ifdef CRC_ENC_ERR_INJECT_EN
    localparam logic INJ_EN = 1'b1;
`else
    // inject_err is still sampled, but masked here, so the flag stays 0.
    localparam logic INJ_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      state, state_nxt;
    logic [7:0]  msg;
    logic [7:0]  sreg;
    logic [3:0]  lfsr;
    logic [2:0]  cnt;
    logic        inj;
    logic        fb;
    logic [3:0]  crc_out;

    assign fb = lfsr[3] ^ sreg[7];

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next state and handshake outputs. A handoff in DONE always returns
    // to IDLE first, so back-to-back transfers are ten cycles apart.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_nxt = SHIFT;
            end
            SHIFT: begin
                if (cnt == 3'd7) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: load the byte on transfer, then run one LFSR step per SHIFT cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            msg  <= 8'h00;
            sreg <= 8'h00;
            lfsr <= 4'h0;
            cnt  <= 3'd0;
            inj  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        msg  <= data_in;
                        sreg <= data_in;
                        lfsr <= 4'h0;
                        cnt  <= 3'd0;
                        inj  <= inject_err & INJ_EN;
                    end
                end
                SHIFT: begin
                    lfsr <= {lfsr[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
                    sreg <= {sreg[6:0], 1'b0};
                    cnt  <= cnt + 3'd1;
                end
                default: ;
            endcase
        end
    end

    // Flip only the CRC LSB, so a downstream check sees a nonzero remainder.
    assign crc_out      = {lfsr[3:1], lfsr[0] ^ (inj & INJ_EN)};
    // The bus reads zero unless a codeword is being presented.
    assign encoded_data = out_valid ? {msg, crc_out} : 12'h000;

endmodule
